hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, meaning number of tracked stages after D (1=E, 2=M, 3=W).
REQ-002 SHALL have parameter TW, default 3, meaning width of all tuse/tnew fields.
REQ-003 SHALL have parameter MULT_LAT, default 5, meaning mult busy cycles; parameter DIV_LAT, default 10, meaning div busy cycles.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports d_rs, d_rt  in  5 each  source register numbers of the instruction in D.
REQ-007 SHALL have ports d_tuse_rs, d_tuse_rt  in  TW each  cycles until D needs the operand; value 3 means unused.
REQ-008 SHALL have port d_a3  in  5  destination register of the D instruction; 0 means no write.
REQ-009 SHALL have port d_tnew  in  TW  cycles after entering E until the result is available.
REQ-010 SHALL have port d_md_start  in  1  D instruction is mult (d_md_div=0) or div (d_md_div=1); d_md_div  in  1.
REQ-011 SHALL have port d_md_use  in  1  D instruction reads or writes HI/LO, or starts mult/div.
REQ-012 SHALL have port stall  out  1  freeze PC and D; insert a bubble into E.
REQ-013 SHALL have ports fwd_rs, fwd_rt  out  clog2(NSTAGE+1) each  0 = register file, k = forward from stage k.
REQ-014 SHALL have port md_busy  out  1  multiply/divide unit is occupied.

Function
REQ-015 SHALL hold per stage k (1..NSTAGE) an entry {a3[4:0], tnew[TW-1:0], md}.
REQ-016 SHALL, each clock: load entry 1 from D when stall=0, or with a bubble {0,0,0} when stall=1; load entry k from entry k-1 for k>=2 with tnew decremented, saturating at 0.
REQ-017 SHALL define a rs match at stage k as d_rs!=0 and entry[k].a3==d_rs; the youngest match (smallest k) alone governs rs; rt is handled identically.
REQ-018 SHALL assert the data stall when the governing match has tnew > d_tuse_rs (or rt equivalent); $0 never stalls.
REQ-019 SHALL drive fwd_rs=k when the governing match has tnew==0, else 0; the same applies to fwd_rt.
REQ-020 SHALL keep a busy counter: load MULT_LAT or DIV_LAT when entry 1 is loaded with md=1; otherwise decrement to 0 and hold there.
REQ-021 SHALL drive md_busy = (counter!=0) | entry[1].md.
REQ-022 SHALL assert the MD stall when d_md_use & md_busy.
REQ-023 SHALL drive stall = data stall | MD stall; stall, fwd_rs, fwd_rt and md_busy are combinational from state and D inputs, with zero-cycle latency.
REQ-024 SHALL, on simultaneous rs and rt hazards, resolve both independently, with stall as their OR.
REQ-025 SHALL, with d_tuse = 3 and a matching entry, never stall, since tnew <= 2 < 3.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, clear all entries to {0,0,0} and the counter to 0, overriding the D load.
REQ-027 SHALL therefore drive stall=0, fwd_rs=fwd_rt=0 and md_busy=0 in the cycle after reset, provided d_md_use=0 or no match exists.
REQ-028 SHALL let a reset mid-multiply abort the counter immediately.

Structure
REQ-029 SHALL place TUSE_NONE=3, MULT_LAT, DIV_LAT and the stage indices E=1, M=2, W=3 in the shared constants header hazard_defs.
REQ-030 SHALL implement the busy counter as sub-module hazard_md_counter, with ports clk, reset, load, is_div and busy.

Verification
REQ-031 SHALL cover: lw $1 (d_tnew=2) in E, D addu reads $1 (tuse=1) -> stall=1 for one cycle; next cycle the entry is in M with tnew=1, stall=0, fwd_rs=0; following cycle fwd_rs=3.
REQ-032 SHALL cover: ori $2 in E (tnew=1), beq in D reads $2 (tuse=0) -> stall=1; after one cycle the entry is in M with tnew=0 -> stall=0, fwd_rs=2.
REQ-033 SHALL cover: $3 written in both E (tnew=0) and M, D reads $3 with tuse=1 -> fwd_rs=1, so the youngest match wins.
REQ-034 SHALL cover: D reads $0 while E holds a3=0 with tnew=2 -> stall=0, fwd=0.
REQ-035 SHALL cover: div enters E, mfhi follows in D -> stall=1 for DIV_LAT+1 cycles, then 0; repeat with mult for MULT_LAT+1 cycles.
REQ-036 SHALL cover: reset asserted 3 cycles into a div -> md_busy=0 and stall=0 in the next cycle.

Source files
------------

// File: rtl/hazard_defs.sv
// Shared constants for the hazard scoreboard: operand-unused marker,
// multiply/divide latencies and the stage numbering behind D.
package hazard_defs;

    localparam int TUSE_NONE = 3;
    localparam int MULT_LAT  = 5;
    localparam int DIV_LAT   = 10;

    localparam int E = 1;
    localparam int M = 2;
    localparam int W = 3;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// Multiply/divide occupancy counter: loaded with the op latency, then
// counts down to zero and holds there.
module hazard_md_counter #(
    parameter int MULT_LAT = hazard_defs::MULT_LAT,
    parameter int DIV_LAT  = hazard_defs::DIV_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    localparam int CW = $clog2(hazard_defs::lat_max(MULT_LAT, DIV_LAT) + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destination/tnew of the stages behind D,
// produces the stall and forwarding selects combinationally from that state.
module hazard_scoreboard #(
    parameter int NSTAGE   = hazard_defs::W,
    parameter int TW       = 3,
    parameter int MULT_LAT = hazard_defs::MULT_LAT,
    parameter int DIV_LAT  = hazard_defs::DIV_LAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [4:0]                     d_rs,
    input  logic [4:0]                     d_rt,
    input  logic [TW-1:0]                  d_tuse_rs,
    input  logic [TW-1:0]                  d_tuse_rt,
    input  logic [4:0]                     d_a3,
    input  logic [TW-1:0]                  d_tnew,
    input  logic                           d_md_start,
    input  logic                           d_md_div,
    input  logic                           d_md_use,
    output logic                           stall,
    output logic [$clog2(NSTAGE+1)-1:0]    fwd_rs,
    output logic [$clog2(NSTAGE+1)-1:0]    fwd_rt,
    output logic                           md_busy
);

    localparam int FW = $clog2(NSTAGE + 1);
    localparam int SE = hazard_defs::E;

    logic [4:0]    r_a3   [1:NSTAGE];
    logic [TW-1:0] r_tnew [1:NSTAGE];
    logic          r_md   [1:NSTAGE];
    logic          r_md_div;

    logic          w_hit_rs;
    logic          w_hit_rt;
    logic [FW-1:0] w_stage_rs;
    logic [FW-1:0] w_stage_rt;
    logic [TW-1:0] w_tnew_rs;
    logic [TW-1:0] w_tnew_rt;
    logic          w_stall_rs;
    logic          w_stall_rt;
    logic          w_md_stall;
    logic          w_cnt_busy;

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        w_hit_rs   = 1'b0;
        w_hit_rt   = 1'b0;
        w_stage_rs = '0;
        w_stage_rt = '0;
        w_tnew_rs  = '0;
        w_tnew_rt  = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (d_rs != 5'd0 && r_a3[k] == d_rs) begin
                w_hit_rs   = 1'b1;
                w_stage_rs = FW'(k);
                w_tnew_rs  = r_tnew[k];
            end
            if (d_rt != 5'd0 && r_a3[k] == d_rt) begin
                w_hit_rt   = 1'b1;
                w_stage_rt = FW'(k);
                w_tnew_rt  = r_tnew[k];
            end
        end
    end

    assign w_stall_rs = w_hit_rs && (w_tnew_rs > d_tuse_rs);
    assign w_stall_rt = w_hit_rt && (w_tnew_rt > d_tuse_rt);
    assign w_md_stall = d_md_use && md_busy;

    assign stall   = w_stall_rs || w_stall_rt || w_md_stall;
    assign fwd_rs  = (w_hit_rs && w_tnew_rs == '0) ? w_stage_rs : '0;
    assign fwd_rt  = (w_hit_rt && w_tnew_rt == '0) ? w_stage_rt : '0;
    assign md_busy = w_cnt_busy || r_md[SE];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_a3[k]   <= '0;
                r_tnew[k] <= '0;
                r_md[k]   <= 1'b0;
            end
            r_md_div <= 1'b0;
        end else begin
            if (stall) begin
                r_a3[SE]   <= '0;
                r_tnew[SE] <= '0;
                r_md[SE]   <= 1'b0;
                r_md_div   <= 1'b0;
            end else begin
                r_a3[SE]   <= d_a3;
                r_tnew[SE] <= d_tnew;
                r_md[SE]   <= d_md_start;
                r_md_div   <= d_md_div;
            end
            for (int k = 2; k <= NSTAGE; k++) begin
                r_a3[k]   <= r_a3[k-1];
                r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
                r_md[k]   <= r_md[k-1];
            end
        end
    end

    // The counter starts while the mult/div sits in E; r_md[E] covers that cycle.
    hazard_md_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (r_md[SE]),
        .is_div (r_md_div),
        .busy   (w_cnt_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized
// traffic against a model that tracks absolute result-ready times.
module tb_hazard_scoreboard;

    localparam int NS   = 3;
    localparam int TWB  = 3;
    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic           clk;
    logic           reset;
    logic [4:0]     d_rs;
    logic [4:0]     d_rt;
    logic [TWB-1:0] d_tuse_rs;
    logic [TWB-1:0] d_tuse_rt;
    logic [4:0]     d_a3;
    logic [TWB-1:0] d_tnew;
    logic           d_md_start;
    logic           d_md_div;
    logic           d_md_use;
    logic           stall;
    logic [1:0]     fwd_rs;
    logic [1:0]     fwd_rt;
    logic           md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per stage the destination and the absolute cycle its value is ready.
    int now;
    int m_a3    [1:NS];
    int m_avail [1:NS];
    int m_md_end;
    bit e_stall;
    int e_fwd_rs;
    int e_fwd_rt;
    bit e_busy;

    hazard_scoreboard #(
        .NSTAGE   (NS),
        .TW       (TWB),
        .MULT_LAT (MLAT),
        .DIV_LAT  (DLAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_d(input int rs, input int rt, input int tu_rs, input int tu_rt,
                         input int a3, input int tnew, input bit st, input bit dv, input bit use_md);
        d_rs       = 5'(rs);
        d_rt       = 5'(rt);
        d_tuse_rs  = TWB'(tu_rs);
        d_tuse_rt  = TWB'(tu_rt);
        d_a3       = 5'(a3);
        d_tnew     = TWB'(tnew);
        d_md_start = st;
        d_md_div   = dv;
        d_md_use   = use_md;
    endtask

    task automatic model_eval();
        bit found_rs;
        bit found_rt;
        int tn;
        found_rs = 0;
        found_rt = 0;
        e_stall  = 0;
        e_fwd_rs = 0;
        e_fwd_rt = 0;
        for (int k = 1; k <= NS; k++) begin
            tn = m_avail[k] - now;
            if (tn < 0) tn = 0;
            if (!found_rs && d_rs != 0 && m_a3[k] == int'(d_rs)) begin
                found_rs = 1;
                if (tn > int'(d_tuse_rs)) e_stall = 1;
                if (tn == 0) e_fwd_rs = k;
            end
            if (!found_rt && d_rt != 0 && m_a3[k] == int'(d_rt)) begin
                found_rt = 1;
                if (tn > int'(d_tuse_rt)) e_stall = 1;
                if (tn == 0) e_fwd_rt = k;
            end
        end
        e_busy = (now <= m_md_end);
        if (d_md_use && e_busy) e_stall = 1;
    endtask

    task automatic model_clear();
        for (int k = 1; k <= NS; k++) begin
            m_a3[k]    = 0;
            m_avail[k] = 0;
        end
        m_md_end = -1;
    endtask

    task automatic model_step();
        model_eval();
        if (reset) begin
            model_clear();
        end else begin
            for (int k = NS; k >= 2; k--) begin
                m_a3[k]    = m_a3[k-1];
                m_avail[k] = m_avail[k-1];
            end
            if (e_stall) begin
                m_a3[1]    = 0;
                m_avail[1] = 0;
            end else begin
                m_a3[1]    = int'(d_a3);
                m_avail[1] = now + 1 + int'(d_tnew);
                if (d_md_start) m_md_end = now + 1 + (d_md_div ? DLAT : MLAT);
            end
        end
        now++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_d(1, 2, 0, 0, 1, 2, 1, 1, 0);
        cycle();
        do_reset();
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++;
        if (fwd_rs !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_rs: got %0d want 0", fwd_rs); end
        n_checks++;
        if (fwd_rt !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_rt: got %0d want 0", fwd_rt); end
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(0, 0, 3, 3, 1, 2, 0, 0, 0);
        cycle();
        set_d(1, 2, 1, 1, 5, 1, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
        cycle();
        n_checks++;
        if (stall !== 1'b0 || fwd_rs !== 2'd0) begin
            n_fail++; $display("FAIL load_use_m: got stall=%b fwd_rs=%0d want 0/0", stall, fwd_rs);
        end
        cycle();
        n_checks++;
        if (stall !== 1'b0 || fwd_rs !== 2'd3) begin
            n_fail++; $display("FAIL load_use_w: got stall=%b fwd_rs=%0d want 0/3", stall, fwd_rs);
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_d(0, 0, 3, 3, 2, 1, 0, 0, 0);
        cycle();
        set_d(2, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL branch_stall: got %b want 1", stall); end
        cycle();
        n_checks++;
        if (stall !== 1'b0 || fwd_rs !== 2'd2) begin
            n_fail++; $display("FAIL branch_fwd: got stall=%b fwd_rs=%0d want 0/2", stall, fwd_rs);
        end
    endtask

    task automatic test_youngest();
        do_reset();
        set_d(0, 0, 3, 3, 3, 0, 0, 0, 0);
        cycle();
        cycle();
        set_d(3, 3, 1, 1, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (fwd_rs !== 2'd1 || fwd_rt !== 2'd1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL youngest: got fwd_rs=%0d fwd_rt=%0d stall=%b want 1/1/0", fwd_rs, fwd_rt, stall);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_d(0, 0, 3, 3, 0, 2, 0, 0, 0);
        cycle();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin
            n_fail++; $display("FAIL zero_reg: got stall=%b fwd_rs=%0d fwd_rt=%0d want 0/0/0", stall, fwd_rs, fwd_rt);
        end
    endtask

    task automatic test_dual();
        do_reset();
        set_d(0, 0, 3, 3, 5, 1, 0, 0, 0);
        cycle();
        set_d(0, 0, 3, 3, 4, 2, 0, 0, 0);
        cycle();
        set_d(5, 4, 0, 1, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 1'b1 || fwd_rs !== 2'd2 || fwd_rt !== 2'd0) begin
            n_fail++; $display("FAIL dual: got stall=%b fwd_rs=%0d fwd_rt=%0d want 1/2/0", stall, fwd_rs, fwd_rt);
        end
        set_d(5, 4, 3, 3, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (stall !== 1'b0 || fwd_rs !== 2'd2) begin
            n_fail++; $display("FAIL dual_unused: got stall=%b fwd_rs=%0d want 0/2", stall, fwd_rs);
        end
    endtask

    task automatic test_md(input bit is_div);
        int n;
        int want;
        want = (is_div ? DLAT : MLAT) + 1;
        do_reset();
        set_d(0, 0, 3, 3, 0, 0, 1, is_div, 1);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL md_start_stall div=%0d: got %b want 0", is_div, stall); end
        cycle();
        set_d(0, 0, 3, 3, 8, 1, 0, 0, 1);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 60) begin
            n++;
            cycle();
        end
        n_checks++;
        if (n != want) begin n_fail++; $display("FAIL md_stall_len div=%0d: got %0d want %0d", is_div, n, want); end
        n_checks++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_done_busy div=%0d: got %b want 0", is_div, md_busy); end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        set_d(0, 0, 3, 3, 0, 0, 1, 1, 1);
        cycle();
        set_d(0, 0, 3, 3, 8, 1, 0, 0, 1);
        cycle();
        cycle();
        cycle();
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_div_stall: got %b want 1", stall); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL mid_div_reset: got busy=%b stall=%b want 0/0", md_busy, stall);
        end
    endtask

    task automatic test_random();
        bit st;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 11) == 0);
            set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), st, $urandom_range(0, 1),
                  st | ($urandom_range(0, 5) == 0));
            reset = ($urandom_range(0, 79) == 0);
            #1;
            model_eval();
            n_checks++;
            if (stall !== e_stall || md_busy !== e_busy) begin
                n_fail++; $display("FAIL rand_stall_busy i=%0d: got stall=%b busy=%b want %b/%b", i, stall, md_busy, e_stall, e_busy);
            end
            n_checks++;
            if (fwd_rs !== 2'(e_fwd_rs) || fwd_rt !== 2'(e_fwd_rt)) begin
                n_fail++; $display("FAIL rand_fwd i=%0d: got rs=%0d rt=%0d want %0d/%0d", i, fwd_rs, fwd_rt, e_fwd_rs, e_fwd_rt);
            end
            cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        now = 0;
        model_clear();
        reset = 1'b1;
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_youngest();
        test_zero_reg();
        test_dual();
        test_md(1'b1);
        test_md(1'b0);
        test_reset_mid_div();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
